serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/Full_adder.sv | 16 +
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared constants and state type for the serial adder
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_SHIFT = SHIFT,
    S_DONE  = DONE
  } state_e;

endpackage

// File: rtl/Full_adder.sv
// rtl/Full_adder.sv - one-bit full adder cell
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry
);

  // Sum and carry of three one-bit inputs
  always_comb begin
    sum   = a ^ b ^ carry_in;
    carry = (a & b) | (a & carry_in) | (b & carry_in);
  end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial unsigned adder, one bit per clock, LSB first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             creg_q, creg_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_sum;
  logic             cell_carry;

  Full_adder u_cell (
    .a        (opa_q[0]),
    .b        (opb_q[0]),
    .carry_in (creg_q),
    .sum      (cell_sum),
    .carry    (cell_carry)
  );

  // Next-state logic: operand capture, per-bit shift, result publication
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    creg_d  = creg_q;
    sreg_d  = sreg_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          creg_d  = carry_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        opa_d  = opa_q >> 1;
        opb_d  = opb_q >> 1;
        creg_d = cell_carry;
        sreg_d = {cell_sum, sreg_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Last bit: the completed word goes straight to the result register
          sum_d   = {cell_sum, sreg_q[WIDTH-1:1]};
          cout_d  = cell_carry;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State register with synchronous reset that overrides any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      creg_q  <= 1'b0;
      sreg_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      creg_q  <= creg_d;
      sreg_q  <= sreg_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for the serial adder
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int errors = 0;
  int checks = 0;

  logic [W:0] exp_q[$];
  int         done_cycs[$];
  int         cyc = 0;
  int         done_count = 0;
  logic       done_prev = 1'b0;
  logic [W:0] prev_res = '0;
  logic       stable_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Output monitor: scoreboard pop on done, pulse width, result stability
  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_count++;
      done_cycs.push_back(cyc);
      chk("done_width", {31'd0, done_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result", {23'd0, carry_out, sum}, {23'd0, e});
      end
    end else if (stable_en) begin
      chk("result_stable", {23'd0, carry_out, sum}, {23'd0, prev_res});
    end
    done_prev = done;
    prev_res  = {carry_out, sum};
  end

  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a = va;
    b = vb;
    carry_in = vc;
    exp_q.push_back({1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc});
  endtask

  // Wait for IDLE, issue one start pulse, then check done latency
  task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, busy}, 32'd0);
    drive(va, vb, vc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    carry_in = $urandom;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'd9);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int dc;
    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, carry_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    stable_en = 1'b1;

    // Directed sums
    op(8'h0F, 8'h01, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hFF, 8'hFF, 1'b1);
    op(8'h00, 8'h00, 1'b0);

    // start and operand changes during SHIFT are ignored
    dc = done_count;
    drive(8'h12, 8'h34, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("ignore_start_dones", done_count - dc, 32'd1);

    // Reset in the 4th SHIFT cycle aborts the operation
    a = 8'h11;
    b = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    stable_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    stable_en = 1'b1;
    dc = done_count;
    for (int i = 0; i < 15; i++) @(negedge clk);
    chk("abort_no_done", done_count - dc, 32'd0);
    op(8'h05, 8'h03, 1'b0);

    // start held high: back-to-back operations every W+2 cycles
    done_cycs.delete();
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (!busy) drive(W'($urandom), W'($urandom), 1'($urandom));
      @(negedge clk);
    end
    start = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_drain", exp_q.size(), 32'd0);
    chk("b2b_count", done_cycs.size(), 32'd3);
    for (int i = 1; i < done_cycs.size(); i++)
      chk("b2b_period", done_cycs[i] - done_cycs[i-1], 32'd10);

    // Random operands against the reference sum
    for (int i = 0; i < 1000; i++)
      op(W'($urandom), W'($urandom), 1'($urandom));

    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("final_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
